// File: rtl/line_arbiter.sv
// Two-requester cache-line arbiter: an instruction cache (port 0) and a data cache
// (port 1) share one next-level memory port, with round-robin tie breaking.
module line_arbiter #(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [31:0]       p0_address,
    input  logic [s_line-1:0] p0_wdata,
    output logic [s_line-1:0] p0_rdata,
    output logic              p0_resp,

    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [31:0]       p1_address,
    input  logic [s_line-1:0] p1_wdata,
    output logic [s_line-1:0] p1_rdata,
    output logic              p1_resp,

    output logic              downstream_read,
    output logic              downstream_write,
    output logic [31:0]       downstream_address,
    output logic [s_line-1:0] downstream_wdata,
    input  logic [s_line-1:0] downstream_rdata,
    input  logic              downstream_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              last_grant, last_grant_next;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic req0, req1;
    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rd_d            = rd_q;
        wr_d            = wr_q;

        unique case (state)
            IDLE: begin
                // On a tie, the port that did not win last time gets the grant.
                if (req0 && (!req1 || last_grant)) begin
                    state_next      = SERVE0;
                    last_grant_next = 1'b0;
                    addr_d          = p0_address;
                    wdata_d         = p0_wdata;
                    wr_d            = p0_write;
                    rd_d            = p0_read & ~p0_write;
                end else if (req1) begin
                    state_next      = SERVE1;
                    last_grant_next = 1'b1;
                    addr_d          = p1_address;
                    wdata_d         = p1_wdata;
                    wr_d            = p1_write;
                    rd_d            = p1_read & ~p1_write;
                end
            end
            SERVE0, SERVE1: begin
                if (downstream_resp) begin
                    state_next = IDLE;
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                rd_d       = 1'b0;
                wr_d       = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed by the combinational block above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // The downstream request comes straight from registers, never from requester inputs.
    assign downstream_read    = rd_q;
    assign downstream_write   = wr_q;
    assign downstream_address = addr_q;
    assign downstream_wdata   = wdata_q;

    assign p0_resp  = (state == SERVE0) & downstream_resp;
    assign p1_resp  = (state == SERVE1) & downstream_resp;
    assign p0_rdata = downstream_rdata;
    assign p1_rdata = downstream_rdata;

endmodule

// File: tb/tb_line_arbiter.sv
// Directed self-checking bench for line_arbiter; the bench plays the downstream
// memory by hand and checks grants, latched fields, resp pulses and reset behaviour.
module tb_line_arbiter;

    localparam int s_line = 256;

    logic              clk;
    logic              rst_n;
    logic              p0_read, p0_write, p1_read, p1_write;
    logic [31:0]       p0_address, p1_address;
    logic [s_line-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic              p0_resp, p1_resp;
    logic              downstream_read, downstream_write;
    logic [31:0]       downstream_address;
    logic [s_line-1:0] downstream_wdata, downstream_rdata;
    logic              downstream_resp;

    int checks = 0;
    int errors = 0;

    line_arbiter #(.s_line(s_line)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .p0_read            (p0_read),
        .p0_write           (p0_write),
        .p0_address         (p0_address),
        .p0_wdata           (p0_wdata),
        .p0_rdata           (p0_rdata),
        .p0_resp            (p0_resp),
        .p1_read            (p1_read),
        .p1_write           (p1_write),
        .p1_address         (p1_address),
        .p1_wdata           (p1_wdata),
        .p1_rdata           (p1_rdata),
        .p1_resp            (p1_resp),
        .downstream_read    (downstream_read),
        .downstream_write   (downstream_write),
        .downstream_address (downstream_address),
        .downstream_wdata   (downstream_wdata),
        .downstream_rdata   (downstream_rdata),
        .downstream_resp    (downstream_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [s_line-1:0] obs,
                         input logic [s_line-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive downstream_resp for one cycle while serving port `port`, check the
    // resp pulse, then check the mandatory IDLE gap after the edge.
    task automatic complete(input int port, input logic [s_line-1:0] data);
        downstream_resp  = 1'b1;
        downstream_rdata = data;
        #1;
        if (port == 0) begin
            check("p0_resp", p0_resp, 1);
            check("p1_resp_quiet", p1_resp, 0);
            check("p0_rdata", p0_rdata, data);
        end else begin
            check("p1_resp", p1_resp, 1);
            check("p0_resp_quiet", p0_resp, 0);
            check("p1_rdata", p1_rdata, data);
        end
        step();
        downstream_resp = 1'b0;
        #1;
        check("idle_gap_rd", downstream_read, 0);
        check("idle_gap_wr", downstream_write, 0);
        check("idle_p0_resp", p0_resp, 0);
        check("idle_p1_resp", p1_resp, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
    endtask

    logic [s_line-1:0] pat_aa, pat_55, pat_w1, pat_w2;

    initial begin
        pat_aa = {(s_line/8){8'hAA}};
        pat_55 = {(s_line/8){8'h55}};
        pat_w1 = {(s_line/32){32'hDEAD_BEEF}};
        pat_w2 = {(s_line/32){32'h1234_5678}};

        {p0_read, p0_write, p1_read, p1_write} = '0;
        p0_address = '0; p1_address = '0;
        p0_wdata = '0; p1_wdata = '0;
        downstream_rdata = '0; downstream_resp = 1'b0;
        rst_n = 1'b0;
        #3;
        check("rst_ds_read", downstream_read, 0);
        check("rst_ds_write", downstream_write, 0);
        check("rst_ds_addr", downstream_address, 0);
        check("rst_ds_wdata", downstream_wdata, 0);
        check("rst_p0_resp", p0_resp, 0);
        check("rst_p1_resp", p1_resp, 0);
        #10;
        rst_n = 1'b1;
        step();

        // Single read from port 0 with a three-cycle downstream latency.
        p0_read = 1'b1; p0_address = 32'h0000_1000;
        step();
        check("rd_ds_read", downstream_read, 1);
        check("rd_ds_write", downstream_write, 0);
        check("rd_ds_addr", downstream_address, 32'h0000_1000);
        p0_read = 1'b0;
        step();
        step();
        check("rd_hold", downstream_read, 1);
        check("rd_no_early_resp", p0_resp, 0);
        complete(0, pat_aa);

        // Tie right after reset: port 0 first, then port 1 write.
        do_reset();
        p0_read = 1'b1; p0_address = 32'h0000_0100;
        p1_write = 1'b1; p1_address = 32'h0000_0200; p1_wdata = pat_w1;
        step();
        check("tie_first_rd", downstream_read, 1);
        check("tie_first_addr", downstream_address, 32'h0000_0100);
        p0_read = 1'b0;
        complete(0, pat_55);
        step();
        check("tie_second_wr", downstream_write, 1);
        check("tie_second_rd", downstream_read, 0);
        check("tie_second_addr", downstream_address, 32'h0000_0200);
        check("tie_second_wdata", downstream_wdata, pat_w1);
        p1_write = 1'b0;
        complete(1, pat_aa);

        // Both ports request continuously; last grant was port 1, so order is 0,1,0,1,0,1.
        p0_read = 1'b1; p0_address = 32'h0000_00A0;
        p1_read = 1'b1; p1_address = 32'h0000_00B0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_read", downstream_read, 1);
            check("rr_addr", downstream_address,
                  (i % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
            complete(i % 2, (i % 2 == 0) ? pat_aa : pat_55);
        end
        p0_read = 1'b0; p1_read = 1'b0;

        // Requester address/data change after grant must not leak downstream.
        p1_read = 1'b1; p1_address = 32'h0000_0040; p1_wdata = pat_w2;
        step();
        check("chg_addr_grant", downstream_address, 32'h0000_0040);
        p1_address = 32'h0000_0080; p1_wdata = pat_w1;
        step();
        check("chg_addr_hold", downstream_address, 32'h0000_0040);
        check("chg_wdata_hold", downstream_wdata, pat_w2);
        check("chg_rd_hold", downstream_read, 1);
        p1_read = 1'b0;
        complete(1, pat_55);

        // Read and write both set counts as a write.
        p0_read = 1'b1; p0_write = 1'b1; p0_address = 32'h0000_0300; p0_wdata = pat_w1;
        step();
        check("rw_write", downstream_write, 1);
        check("rw_read", downstream_read, 0);
        check("rw_wdata", downstream_wdata, pat_w1);
        p0_read = 1'b0; p0_write = 1'b0;
        complete(0, pat_aa);

        // Spurious downstream_resp in IDLE is ignored.
        downstream_resp = 1'b1;
        #1;
        check("spur_p0_resp", p0_resp, 0);
        check("spur_p1_resp", p1_resp, 0);
        step();
        check("spur_no_rd", downstream_read, 0);
        check("spur_no_wr", downstream_write, 0);
        downstream_resp = 1'b0;

        // Reset during SERVE0 drops the request immediately.
        p0_read = 1'b1; p0_address = 32'h0000_0500;
        step();
        check("abort_pre_rd", downstream_read, 1);
        p0_read = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_rd", downstream_read, 0);
        check("abort_async_addr", downstream_address, 0);
        #10;
        p1_write = 1'b1; p1_address = 32'h0000_0600; p1_wdata = pat_w2;
        rst_n = 1'b1;
        step();
        check("post_rst_wr", downstream_write, 1);
        check("post_rst_addr", downstream_address, 32'h0000_0600);
        p1_write = 1'b0;
        complete(1, pat_55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_arbiter.md
LINE_ARBITER -- requirements
Module: line_arbiter

Interface
REQ-001 The block SHALL have parameter s_line, default 256, meaning the cache-line width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports p0_read and p0_write, input, 1 bit each: requester 0 (instruction cache) line read and write requests.
REQ-005 The block SHALL have port p0_address, input, 32 bits, and port p0_wdata, input, s_line bits: requester 0 line address and write data.
REQ-006 The block SHALL have port p0_rdata, output, s_line bits, and port p0_resp, output, 1 bit: requester 0 read data and completion pulse.
REQ-007 The block SHALL have ports p1_read, p1_write, p1_address, p1_wdata, p1_rdata and p1_resp for requester 1 (data cache), with directions and widths identical to the p0_* ports.
REQ-008 The block SHALL have ports downstream_read and downstream_write, output, 1 bit each, and downstream_address, output, 32 bits: the shared next-level request.
REQ-009 The block SHALL have port downstream_wdata, output, s_line bits; port downstream_rdata, input, s_line bits; and port downstream_resp, input, 1 bit.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SERVE0 and SERVE1; IDLE is the reset state.
REQ-011 A port is requesting when its read or write is 1; when read and write are both 1, the block SHALL treat the request as a write.
REQ-012 In IDLE with only one port requesting, the block SHALL grant that port (SERVEn) at the next edge.
REQ-013 In IDLE with both ports requesting, the block SHALL grant the port not recorded in the 1-bit last-grant register.
REQ-014 The last-grant register SHALL reset to 1, so requester 0 wins the first tie, and SHALL update at every grant.
REQ-015 At the grant edge the block SHALL latch the granted port's address, wdata and op (read or write) into internal registers.
REQ-016 downstream_address, downstream_wdata, downstream_read and downstream_write SHALL be driven only from the registers in REQ-015.
REQ-017 Latency: a request sampled in IDLE at edge N SHALL assert downstream_read or downstream_write in the cycle after edge N; there is no combinational request path.
REQ-018 In SERVEn, the block SHALL hold downstream_read or downstream_write (exactly one) and all latched fields stable until downstream_resp is 1.
REQ-019 In SERVEn with downstream_resp = 1, the block SHALL drive pn_resp = 1 combinationally in that same cycle and SHALL return to IDLE at the next edge.
REQ-020 pn_rdata SHALL equal downstream_rdata combinationally at all times; it is meaningful only while pn_resp = 1.
REQ-021 The non-granted port's resp SHALL be 0 at all times.
REQ-022 downstream_resp received in IDLE SHALL be ignored: no resp output and no state change.
REQ-023 IDLE SHALL last at least one cycle between transactions; back-to-back grants are therefore separated by a single IDLE cycle.
REQ-024 A requester deasserting its request while in SERVEn SHALL NOT abort the transaction; the downstream access completes and the resp pulse is still issued.
REQ-025 Changes to a requester's address or wdata after grant SHALL NOT affect the downstream transaction in progress.
REQ-026 A requester whose request is held through the cycle it receives resp SHALL be arbitrated as a new request in the following IDLE cycle.

Reset
REQ-027 While rst_n = 0, the block SHALL hold: state IDLE; last-grant = 1; latched registers 0; downstream_read, downstream_write, p0_resp and p1_resp all 0; downstream_address and downstream_wdata 0.
REQ-028 Reset assertion mid-transaction SHALL drop downstream_read and downstream_write asynchronously and abandon the transaction; the downstream must be reset concurrently.
REQ-029 After rst_n deasserts, the first rising edge SHALL perform normal IDLE arbitration.

Verification
REQ-030 Single read: p0_read = 1, address 0x0000_1000; downstream_resp after 3 cycles returning 0xAA..AA -> downstream_read = 1 one cycle after request, address 0x0000_1000, p0_resp pulses one cycle with p0_rdata = 0xAA..AA.
REQ-031 Tie after reset: p0_read and p1_write asserted together -> port 0 served first, then one IDLE cycle, then port 1 write with p1_wdata on downstream_wdata.
REQ-032 Round-robin: both ports continuously requesting for 6 transactions -> grant order 0,1,0,1,0,1, with no port served twice in a row.
REQ-033 Address change after grant: p1 address changed from 0x40 to 0x80 during SERVE1 -> downstream_address stays 0x40 until resp.
REQ-034 Spurious and abort cases: downstream_resp pulsed in IDLE -> no resp and no grant; rst_n low during SERVE0 -> downstream_read 0 immediately and IDLE after release.
REQ-035 Read and write both set: p0_read = p0_write = 1 -> downstream_write = 1 and downstream_read = 0.
